wb_merge: RTL and testbench

Writeback merge stage that sits directly upstream of the register file write port. It accepts in-order results from the main pipeline and out-of-order results from long-latency units (divider, AMO/load miss path), buffers the latter in a small FIFO, and arbitrates both onto the single RF write port. It also keeps a pending-destination scoreboard so decode can stall on operands and destinations still owed by a long-latency unit.

---
 rtl/wb_merge.sv | 114 +++++++++++
 tb/tb_wb_merge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
// Writeback merge: arbitrates in-order pipeline results and buffered long-latency results onto the RF write port.
// Optional pending-destination scoreboard is enabled with `define WB_SCOREBOARD_EN.
module wb_merge #(
   parameter int unsigned LL_DEPTH  = 2,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RF_AWIDTH = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           pipe_wr_req_i,
   input  logic [RF_AWIDTH-1:0]           pipe_rd_addr_i,
   input  logic [XLEN-1:0]                pipe_rd_data_i,
   input  logic                           ll_issue_i,
   input  logic [RF_AWIDTH-1:0]           ll_issue_rd_i,
   input  logic                           ll_valid_i,
   input  logic [RF_AWIDTH-1:0]           ll_rd_addr_i,
   input  logic [XLEN-1:0]                ll_rd_data_i,
   output logic                           ll_ready_o,
   output logic [$clog2(LL_DEPTH):0]      ll_count_o,
   input  logic [RF_AWIDTH-1:0]           id_rs1_addr_i,
   input  logic [RF_AWIDTH-1:0]           id_rs2_addr_i,
   input  logic [RF_AWIDTH-1:0]           id_rd_addr_i,
   output logic                           hazard_o,
   output logic                           wb2rf_rd_wr_req_o,
   output logic [RF_AWIDTH-1:0]           wb2rf_rd_addr_o,
   output logic [XLEN-1:0]                wb2rf_rd_data_o
);

   localparam int unsigned PW      = $clog2(LL_DEPTH);
   localparam int unsigned CW      = PW + 1;
   localparam int unsigned RF_SIZE = 1 << RF_AWIDTH;

   typedef struct packed {
      logic [RF_AWIDTH-1:0] addr;
      logic [XLEN-1:0]      data;
   } ll_entry_t;

   ll_entry_t         fifo_mem [LL_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              pipe_sel;
   logic              pop;
   logic              push;
   ll_entry_t         head;

   assign head       = fifo_mem[rd_ptr];
   assign ll_ready_o = rst_n & (count < CW'(LL_DEPTH));
   assign ll_count_o = count;
   assign pipe_sel   = rst_n & pipe_wr_req_i & (pipe_rd_addr_i != '0);
   assign pop        = rst_n & ~pipe_sel & (count != '0);
   // rd=0 results are handshaken but never stored
   assign push       = ll_valid_i & ll_ready_o & (ll_rd_addr_i != '0);

   // Fixed-priority RF port mux: pipeline first, FIFO head only in idle cycles
   always_comb begin
      wb2rf_rd_wr_req_o = 1'b0;
      wb2rf_rd_addr_o   = '0;
      wb2rf_rd_data_o   = '0;
      if (pipe_sel) begin
         wb2rf_rd_wr_req_o = 1'b1;
         wb2rf_rd_addr_o   = pipe_rd_addr_i;
         wb2rf_rd_data_o   = pipe_rd_data_i;
      end else if (pop) begin
         wb2rf_rd_wr_req_o = 1'b1;
         wb2rf_rd_addr_o   = head.addr;
         wb2rf_rd_data_o   = head.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Payload storage carries no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{addr: ll_rd_addr_i, data: ll_rd_data_i};
   end

`ifdef WB_SCOREBOARD_EN
   logic [RF_SIZE-1:0] pending;
   logic [RF_SIZE-1:0] pend_set;
   logic [RF_SIZE-1:0] pend_clr;

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (ll_issue_i && (ll_issue_rd_i != '0)) pend_set[ll_issue_rd_i] = 1'b1;
      if (pop)                                  pend_clr[head.addr]     = 1'b1;
   end

   // Set wins over a same-cycle clear of the same register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~pend_clr) | pend_set;
   end

   assign hazard_o = pending[id_rs1_addr_i] | pending[id_rs2_addr_i] | pending[id_rd_addr_i];
`else
   logic unused_sb;
   assign unused_sb = ^{ll_issue_i, ll_issue_rd_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i};
   assign hazard_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: queue-based reference model, directed scenarios, then random traffic.
module tb_wb_merge;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 2;
`ifdef WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            pipe_wr_req_i;
   logic [AW-1:0]   pipe_rd_addr_i;
   logic [XLEN-1:0] pipe_rd_data_i;
   logic            ll_issue_i;
   logic [AW-1:0]   ll_issue_rd_i;
   logic            ll_valid_i;
   logic [AW-1:0]   ll_rd_addr_i;
   logic [XLEN-1:0] ll_rd_data_i;
   logic            ll_ready_o;
   logic [1:0]      ll_count_o;
   logic [AW-1:0]   id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
   logic            hazard_o;
   logic            wb2rf_rd_wr_req_o;
   logic [AW-1:0]   wb2rf_rd_addr_o;
   logic [XLEN-1:0] wb2rf_rd_data_o;

   always #5 clk = ~clk;

   wb_merge #(.LL_DEPTH(DEPTH), .XLEN(XLEN), .RF_AWIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_wr_req_i(pipe_wr_req_i), .pipe_rd_addr_i(pipe_rd_addr_i), .pipe_rd_data_i(pipe_rd_data_i),
      .ll_issue_i(ll_issue_i), .ll_issue_rd_i(ll_issue_rd_i),
      .ll_valid_i(ll_valid_i), .ll_rd_addr_i(ll_rd_addr_i), .ll_rd_data_i(ll_rd_data_i),
      .ll_ready_o(ll_ready_o), .ll_count_o(ll_count_o),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
      .hazard_o(hazard_o),
      .wb2rf_rd_wr_req_o(wb2rf_rd_wr_req_o), .wb2rf_rd_addr_o(wb2rf_rd_addr_o),
      .wb2rf_rd_data_o(wb2rf_rd_data_o)
   );

   typedef struct packed {
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
   } res_t;

   res_t m_q[$];     // model of buffered results, in drain order
   res_t src_q[$];   // results the long-latency units are offering
   bit   m_pend[32];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_src();
      if (src_q.size() > 0) begin
         ll_valid_i   = 1'b1;
         ll_rd_addr_i = src_q[0].a;
         ll_rd_data_i = src_q[0].d;
      end else begin
         ll_valid_i   = 1'b0;
         ll_rd_addr_i = '0;
         ll_rd_data_i = '0;
      end
   endtask

   task automatic lit_pre();
      drive_src();
      #1;
   endtask

   // Called just after a negedge with inputs set; compares, then advances the model across the posedge
   task automatic cycle_check();
      bit              psel, drain, acc, e_rdy, e_hz;
      logic [AW-1:0]   e_a;
      logic [XLEN-1:0] e_d;
      if (!rst_n) begin
         m_q.delete();
         src_q.delete();
         foreach (m_pend[i]) m_pend[i] = 1'b0;
      end
      drive_src();
      #1;
      psel  = rst_n && pipe_wr_req_i && (pipe_rd_addr_i != 0);
      drain = rst_n && !psel && (m_q.size() > 0);
      e_a   = psel ? pipe_rd_addr_i : (drain ? m_q[0].a : '0);
      e_d   = psel ? pipe_rd_data_i : (drain ? m_q[0].d : '0);
      e_rdy = rst_n && (m_q.size() < DEPTH);
      e_hz  = SB && (m_pend[id_rs1_addr_i] || m_pend[id_rs2_addr_i] || m_pend[id_rd_addr_i]);
      chk("req",   64'(wb2rf_rd_wr_req_o), 64'(psel || drain));
      chk("addr",  64'(wb2rf_rd_addr_o),   64'(e_a));
      chk("data",  64'(wb2rf_rd_data_o),   64'(e_d));
      chk("ready", 64'(ll_ready_o),        64'(e_rdy));
      chk("count", 64'(ll_count_o),        64'(m_q.size()));
      chk("hazard",64'(hazard_o),          64'(e_hz));
      @(posedge clk);
      if (rst_n) begin
         acc = ll_valid_i && e_rdy;
         if (drain) begin
            m_pend[m_q[0].a] = 1'b0;
            void'(m_q.pop_front());
         end
         if (acc) begin
            if (src_q[0].a != 0) m_q.push_back(src_q[0]);
            void'(src_q.pop_front());
         end
         if (ll_issue_i && ll_issue_rd_i != 0) m_pend[ll_issue_rd_i] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic pipe(input bit v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      pipe_wr_req_i  = v;
      pipe_rd_addr_i = a;
      pipe_rd_data_i = d;
   endtask

   logic [AW-1:0] prev;

   initial begin
      rst_n = 1'b0;
      pipe(0, '0, '0);
      ll_issue_i = 1'b0; ll_issue_rd_i = '0;
      id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rd_addr_i = '0;
      drive_src();
      @(negedge clk);
      lit_pre();
      chk("rst_req",   64'(wb2rf_rd_wr_req_o), 64'd0);
      chk("rst_ready", 64'(ll_ready_o),        64'd0);
      chk("rst_count", 64'(ll_count_o),        64'd0);
      chk("rst_hazard",64'(hazard_o),          64'd0);
      cycle_check();
      rst_n = 1'b1;

      // Pipeline passthrough, and x0 suppression
      pipe(1, 5'd5, 32'h1234);
      lit_pre();
      chk("p5_req",  64'(wb2rf_rd_wr_req_o), 64'd1);
      chk("p5_addr", 64'(wb2rf_rd_addr_o),   64'd5);
      chk("p5_data", 64'(wb2rf_rd_data_o),   64'h1234);
      cycle_check();
      pipe(1, 5'd0, 32'hFFFF);
      lit_pre();
      chk("p0_req", 64'(wb2rf_rd_wr_req_o), 64'd0);
      cycle_check();
      pipe(0, '0, '0);

      // Single LL result: accepted at N, written in N+1
      src_q.push_back('{a: 5'd7, d: 32'hDEAD});
      cycle_check();
      lit_pre();
      chk("ll7_req",   64'(wb2rf_rd_wr_req_o), 64'd1);
      chk("ll7_addr",  64'(wb2rf_rd_addr_o),   64'd7);
      chk("ll7_data",  64'(wb2rf_rd_data_o),   64'hDEAD);
      chk("ll7_cnt1",  64'(ll_count_o),        64'd1);
      cycle_check();
      lit_pre();
      chk("ll7_cnt0",  64'(ll_count_o),        64'd0);
      chk("ll7_idle",  64'(wb2rf_rd_wr_req_o), 64'd0);
      cycle_check();

      // Backpressure under continuous pipeline writes
      src_q.push_back('{a: 5'd10, d: 32'hA1});
      src_q.push_back('{a: 5'd11, d: 32'hA2});
      src_q.push_back('{a: 5'd12, d: 32'hA3});
      for (int i = 0; i < 6; i++) begin
         pipe(1, 5'd1, 32'(i));
         if (i >= 2) begin
            lit_pre();
            chk("bp_cnt",   64'(ll_count_o), 64'd2);
            chk("bp_ready", 64'(ll_ready_o), 64'd0);
            chk("bp_held",  64'(ll_valid_i), 64'd1);
         end
         cycle_check();
      end
      pipe(0, '0, '0);
      lit_pre();
      chk("bp_drain0", 64'(wb2rf_rd_addr_o), 64'd10);
      cycle_check();
      lit_pre();
      chk("bp_drain1", 64'(wb2rf_rd_addr_o), 64'd11);
      cycle_check();
      cycle_check();
      cycle_check();

      // Scoreboard: issue x9, hazard until the cycle after x9 drains
      ll_issue_i = 1'b1; ll_issue_rd_i = 5'd9; id_rs1_addr_i = 5'd9;
      lit_pre();
      chk("hz_pre", 64'(hazard_o), 64'd0);
      cycle_check();
      ll_issue_i = 1'b0;
      lit_pre();
      chk("hz_set", 64'(hazard_o), 64'(SB));
      cycle_check();
      cycle_check();
      src_q.push_back('{a: 5'd9, d: 32'h99});
      cycle_check();
      lit_pre();
      chk("hz_drain_cyc", 64'(hazard_o), 64'(SB));
      chk("hz_drain_req", 64'(wb2rf_rd_addr_o), 64'd9);
      cycle_check();
      lit_pre();
      chk("hz_clr", 64'(hazard_o), 64'd0);
      cycle_check();
      id_rs1_addr_i = '0;

      // Simultaneous push/pop at count 1 across pointer wrap
      prev = 5'd3;
      src_q.push_back('{a: 5'd3, d: 32'h300});
      cycle_check();
      for (int i = 0; i < 5; i++) begin
         src_q.push_back('{a: AW'(20 + i), d: 32'(i)});
         lit_pre();
         chk("pp_cnt",  64'(ll_count_o),      64'd1);
         chk("pp_addr", 64'(wb2rf_rd_addr_o), 64'(prev));
         cycle_check();
         prev = AW'(20 + i);
      end
      lit_pre();
      chk("pp_last", 64'(wb2rf_rd_addr_o), 64'd24);
      cycle_check();

      // Reset mid-drain with count 2 and a pending bit
      src_q.push_back('{a: 5'd13, d: 32'hD13});
      src_q.push_back('{a: 5'd14, d: 32'hD14});
      pipe(1, 5'd2, 32'h2);
      ll_issue_i = 1'b1; ll_issue_rd_i = 5'd15; id_rd_addr_i = 5'd15;
      cycle_check();
      ll_issue_i = 1'b0;
      cycle_check();
      pipe(0, '0, '0);
      lit_pre();
      chk("md_req",  64'(wb2rf_rd_wr_req_o), 64'd1);
      chk("md_cnt",  64'(ll_count_o),        64'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_req",  64'(wb2rf_rd_wr_req_o), 64'd0);
      chk("mr_cnt",  64'(ll_count_o),        64'd0);
      chk("mr_hz",   64'(hazard_o),          64'd0);
      chk("mr_rdy",  64'(ll_ready_o),        64'd0);
      @(negedge clk);
      cycle_check();
      rst_n = 1'b1;
      lit_pre();
      chk("post_req", 64'(wb2rf_rd_wr_req_o), 64'd0);
      chk("post_cnt", 64'(ll_count_o),        64'd0);
      cycle_check();
      id_rd_addr_i = '0;

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         pipe(($urandom % 100) < 55, AW'($urandom), $urandom);
         if (src_q.size() == 0 && ($urandom % 3) == 0)
            src_q.push_back('{a: (($urandom % 8) == 0) ? '0 : AW'($urandom), d: $urandom});
         ll_issue_rd_i = AW'($urandom);
         ll_issue_i    = (($urandom % 5) == 0) && !m_pend[ll_issue_rd_i];
         id_rs1_addr_i = AW'($urandom);
         id_rs2_addr_i = AW'($urandom);
         id_rd_addr_i  = AW'($urandom);
         if (n == 1500) rst_n = 1'b0;
         if (n == 1502) rst_n = 1'b1;
         cycle_check();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
